// File: rtl/imm_pkg.sv
// Shared types and helpers for the multi-word immediate assembler.
// Default word geometry matches the 8-bit instruction memory.
package imm_pkg;

  localparam int WORD_W_DEF    = 8;
  localparam int MAX_WORDS_DEF = 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    HOLD    = 2'd2
  } state_t;

  // Bit offset of slot idx inside the assembled operand.
  function automatic int slot_off(input int idx, input int word_w);
    return idx * word_w;
  endfunction

endpackage

// File: rtl/imm_assembler.sv
// Collects 1..MAX_WORDS instruction words (word 0 least significant) into one
// zero-extended operand, offered downstream with a valid/ready handshake.
module imm_assembler
  import imm_pkg::*;
#(
  parameter int WORD_W    = WORD_W_DEF,
  parameter int MAX_WORDS = MAX_WORDS_DEF,
  parameter int LEN_W     = $clog2(MAX_WORDS + 1)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic [LEN_W-1:0]            start_len,
  input  logic                        flush,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [WORD_W-1:0]           in_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [WORD_W*MAX_WORDS-1:0] out_imm,
  output logic [LEN_W-1:0]            out_len,
  output logic                        busy,
  output logic                        err
);

  localparam int IMM_W = WORD_W * MAX_WORDS;

  state_t             state_q, state_d;
  logic [LEN_W-1:0]   idx_q, idx_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [IMM_W-1:0]   asm_q, asm_d;
  logic [IMM_W-1:0]   imm_d;
  logic [LEN_W-1:0]   olen_d;
  logic               vld_d;
  logic               err_d;
  logic               start_req;
  logic               len_legal;

  assign in_ready  = (state_q == COLLECT);
  assign busy      = (state_q != IDLE);
  assign len_legal = (start_len != '0) && (start_len <= LEN_W'(MAX_WORDS));
  // A start is honoured from IDLE, or from HOLD when the operand leaves this cycle.
  assign start_req = start && ((state_q == IDLE) || ((state_q == HOLD) && out_ready));

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    len_d   = len_q;
    asm_d   = asm_q;
    imm_d   = out_imm;
    olen_d  = out_len;
    vld_d   = out_valid;
    err_d   = 1'b0;
    if (flush) begin
      state_d = IDLE;
      idx_d   = '0;
      imm_d   = '0;
      olen_d  = '0;
      vld_d   = 1'b0;
    end else begin
      case (state_q)
        COLLECT: begin
          if (start) err_d = 1'b1;
          if (in_valid) begin
            asm_d[slot_off(int'(idx_q), WORD_W) +: WORD_W] = in_data;
            if (idx_q == len_q - LEN_W'(1)) begin
              state_d = HOLD;
              imm_d   = asm_d;
              olen_d  = len_q;
              vld_d   = 1'b1;
            end else begin
              idx_d = idx_q + LEN_W'(1);
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            state_d = IDLE;
            vld_d   = 1'b0;
          end else if (start) begin
            err_d = 1'b1;
          end
        end
        default: ;
      endcase
      if (start_req) begin
        if (len_legal) begin
          state_d = COLLECT;
          asm_d   = '0;
          len_d   = start_len;
          idx_d   = '0;
        end else begin
          err_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      len_q     <= '0;
      asm_q     <= '0;
      out_imm   <= '0;
      out_len   <= '0;
      out_valid <= 1'b0;
      err       <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      len_q     <= len_d;
      asm_q     <= asm_d;
      out_imm   <= imm_d;
      out_len   <= olen_d;
      out_valid <= vld_d;
      err       <= err_d;
    end
  end

endmodule

// File: tb/tb_imm_assembler.sv
// Directed bench for imm_assembler: an operand-level reference model checked
// every cycle, plus literal expectations for each scenario.
module tb_imm_assembler;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  start_len = '0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_imm;
  logic [1:0]  out_len;
  logic        busy;
  logic        err;

  int errors = 0;
  int checks = 0;
  bit cmp_en = 1'b0;

  imm_assembler dut (
    .clk(clk), .rst_n(rst_n), .start(start), .start_len(start_len),
    .flush(flush), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_imm(out_imm),
    .out_len(out_len), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: phase 0 = no operand, 1 = gathering words, 2 = operand offered.
  int phase, m_len, m_cnt, m_acc;
  int e_vld, e_imm, e_len, e_err;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase = 0; m_len = 0; m_cnt = 0; m_acc = 0;
      e_vld = 0; e_imm = 0; e_len = 0; e_err = 0;
    end else begin
      int  p0;
      bit  can_start;
      p0 = phase;
      e_err = 0;
      if (flush) begin
        phase = 0; e_vld = 0; e_imm = 0; e_len = 0;
      end else begin
        can_start = (p0 == 0) || (p0 == 2 && out_ready);
        if (p0 == 2 && out_ready) begin
          phase = 0;
          e_vld = 0;
        end
        if (p0 == 1 && in_valid) begin
          m_acc = m_acc + int'(in_data) * (1 << (8 * m_cnt));
          m_cnt++;
          if (m_cnt == m_len) begin
            phase = 2; e_vld = 1; e_imm = m_acc; e_len = m_len;
          end
        end
        if (start) begin
          if (can_start && start_len >= 1 && start_len <= 2) begin
            phase = 1; m_len = int'(start_len); m_cnt = 0; m_acc = 0;
          end else begin
            e_err = 1;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en && rst_n) begin
      chk("out_valid", int'(out_valid), e_vld);
      chk("out_imm",   int'(out_imm),   e_imm);
      chk("out_len",   int'(out_len),   e_len);
      chk("err",       int'(err),       e_err);
      chk("busy",      int'(busy),      int'(phase != 0));
      chk("in_ready",  int'(in_ready),  int'(phase == 1));
    end
  end

  task automatic cyc(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_start(input logic [1:0] len);
    start = 1'b1; start_len = len;
    cyc();
    start = 1'b0; start_len = '0;
  endtask

  task automatic word(input logic [7:0] d);
    in_valid = 1'b1; in_data = d;
    cyc();
    in_valid = 1'b0; in_data = '0;
  endtask

  task automatic consume;
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;
  endtask

  initial begin
    cyc(2);
    rst_n = 1'b1;
    cmp_en = 1'b1;
    cyc();
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_imm",   int'(out_imm),   0);
    chk("rst_busy",      int'(busy),      0);

    // Single-word operand
    do_start(2'd1);
    word(8'h42);
    chk("one_imm", int'(out_imm), 16'h0042);
    chk("one_len", int'(out_len), 1);
    cyc(2);
    chk("one_hold", int'(out_valid), 1);
    consume();
    chk("one_idle", int'(busy), 0);

    // Two words with a gap
    do_start(2'd2);
    word(8'h34);
    cyc();
    word(8'h12);
    chk("two_imm",   int'(out_imm),  16'h1234);
    chk("two_ready", int'(in_ready), 0);

    // Back-to-back start on the handshake cycle
    out_ready = 1'b1; start = 1'b1; start_len = 2'd2;
    cyc();
    out_ready = 1'b0; start = 1'b0; start_len = '0;
    chk("b2b_busy",  int'(busy),      1);
    chk("b2b_valid", int'(out_valid), 0);
    word(8'hEF);
    word(8'hBE);
    chk("b2b_imm", int'(out_imm), 16'hBEEF);
    consume();

    // Illegal lengths, then a start during collection
    do_start(2'd0);
    chk("len0_err",  int'(err),  1);
    chk("len0_busy", int'(busy), 0);
    do_start(2'd3);
    chk("len3_err", int'(err), 1);
    do_start(2'd2);
    start = 1'b1; start_len = 2'd1;
    word(8'h11);
    start = 1'b0; start_len = '0;
    chk("col_err", int'(err), 1);
    word(8'h22);
    chk("col_imm", int'(out_imm), 16'h2211);
    consume();

    // Flush on the final word accept
    do_start(2'd2);
    word(8'h55);
    flush = 1'b1;
    word(8'h66);
    flush = 1'b0;
    chk("flush_valid", int'(out_valid), 0);
    chk("flush_imm",   int'(out_imm),   0);
    chk("flush_err",   int'(err),       0);
    cyc();
    do_start(2'd1);
    word(8'h7A);
    chk("post_flush_imm", int'(out_imm), 16'h007A);
    consume();

    // Asynchronous reset after one of two words
    do_start(2'd2);
    word(8'h99);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", int'(out_valid), 0);
    chk("arst_imm",   int'(out_imm),   0);
    chk("arst_len",   int'(out_len),   0);
    chk("arst_busy",  int'(busy),      0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    cyc();
    do_start(2'd1);
    word(8'h5A);
    chk("post_rst_imm", int'(out_imm), 16'h005A);
    consume();
    cyc(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
